// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared data/address widths and requester ids for the DRAM arbiter.
// The width defines are guarded so any other file of the slice may also provide them.
`ifndef DRAM_ARB_DEFINES
`define DRAM_ARB_DEFINES
`define WIDTH 32
`define ADDR_WIDTH 12
`endif

package dram_arb_pkg;

  // Requester index: CPU is 0, DMA is 1.
  typedef enum logic {
    CPU = 1'b0,
    DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/dram_arb.sv
// dram_arb: two-requester (CPU, DMA) arbiter for a single-port data memory.
// Grants are combinational; read responses return one cycle after the grant.
// Build option: define DRAM_ARB_RR_EN for round-robin contention resolution;
// otherwise fixed CPU priority with a DMA starvation guard of STARVE_LIMIT cycles.
module dram_arb
  import dram_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   c_req_i,
  input  logic                   c_we_i,
  input  logic [`ADDR_WIDTH-1:0] c_addr_i,
  input  logic [`WIDTH-1:0]      c_wdata_i,
  output logic                   c_gnt_o,
  output logic                   c_rvalid_o,
  output logic [`WIDTH-1:0]      c_rdata_o,
  input  logic                   d_req_i,
  input  logic                   d_we_i,
  input  logic [`ADDR_WIDTH-1:0] d_addr_i,
  input  logic [`WIDTH-1:0]      d_wdata_i,
  output logic                   d_gnt_o,
  output logic                   d_rvalid_o,
  output logic [`WIDTH-1:0]      d_rdata_o,
  output logic                   mem_we_o,
  output logic [`ADDR_WIDTH-1:0] mem_addr_o,
  output logic [`WIDTH-1:0]      mem_wdata_o,
  input  logic [`WIDTH-1:0]      mem_rdata_i
);

  logic    c_win;
  logic    d_win;
  logic    rsp_vld_p1;
  req_id_e rsp_id_p1;

`ifdef DRAM_ARB_RR_EN
  req_id_e rr_ptr;
`else
  localparam int CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [CNT_W-1:0] starve_cnt;
`endif

  // Pick the winner: a lone requester always wins, contention goes to the mode's rule.
  always_comb begin
    c_win = 1'b0;
    d_win = 1'b0;
    if (c_req_i && d_req_i) begin
`ifdef DRAM_ARB_RR_EN
      d_win = (rr_ptr == DMA);
`else
      d_win = (starve_cnt == CNT_W'(STARVE_LIMIT));
`endif
      c_win = !d_win;
    end else begin
      c_win = c_req_i;
      d_win = d_req_i;
    end
  end

  // Grants are forced low while reset is held, independent of the request inputs.
  assign c_gnt_o = c_win & rst_n;
  assign d_gnt_o = d_win & rst_n;

  // Steer the granted port's payload onto the memory port; idle drives zeros.
  always_comb begin
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (c_gnt_o) begin
      mem_we_o    = c_we_i;
      mem_addr_o  = c_addr_i;
      mem_wdata_o = c_wdata_i;
    end else if (d_gnt_o) begin
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end
  end

  // ---- stage p1: response tag for the read granted in the previous cycle ----
  // Tag a granted read with its requester so the memory's next-cycle data is routed back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_p1 <= 1'b0;
      rsp_id_p1  <= CPU;
    end else begin
      rsp_vld_p1 <= (c_gnt_o & ~c_we_i) | (d_gnt_o & ~d_we_i);
      rsp_id_p1  <= d_gnt_o ? DMA : CPU;
    end
  end

`ifdef DRAM_ARB_RR_EN
  // Round-robin pointer names the requester that wins the next tie: the one not granted last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= CPU;
    end else if (c_gnt_o) begin
      rr_ptr <= DMA;
    end else if (d_gnt_o) begin
      rr_ptr <= CPU;
    end
  end
`else
  // Count consecutive denied DMA cycles, saturating; any DMA grant or idle DMA clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!d_req_i || d_gnt_o) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end
`endif

  assign c_rvalid_o = rsp_vld_p1 && (rsp_id_p1 == CPU);
  assign d_rvalid_o = rsp_vld_p1 && (rsp_id_p1 == DMA);
  assign c_rdata_o  = mem_rdata_i;
  assign d_rdata_o  = mem_rdata_i;

endmodule

// File: doc/dram_arb.md
DRAM_ARB -- requirements
Module: dram_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the number of consecutive denied DMA-request cycles tolerated in fixed-priority mode.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports c_req_i / c_we_i  input  1 each  CPU access request / write enable.
REQ-005 SHALL have ports c_addr_i  input  `ADDR_WIDTH and c_wdata_i  input  `WIDTH  CPU byte address / write data.
REQ-006 SHALL have ports c_gnt_o / c_rvalid_o  output  1 each and c_rdata_o  output  `WIDTH  CPU grant / read-valid / read data.
REQ-007 SHALL have ports d_req_i, d_we_i, d_addr_i, d_wdata_i, d_gnt_o, d_rvalid_o, d_rdata_o with the CPU widths, for the DMA requester.
REQ-008 SHALL have ports mem_we_o  output  1, mem_addr_o  output  `ADDR_WIDTH, mem_wdata_o  output  `WIDTH  driving the data-memory port.
REQ-009 SHALL have port mem_rdata_i  input  `WIDTH  data-memory read data, valid one cycle after the address.

Function
REQ-010 SHALL grant at most one requester per cycle; a grant is combinational from the req inputs and registered arbitration state.
REQ-011 SHALL, on a grant, drive mem_addr_o, mem_wdata_o and mem_we_o from the granted port in the same cycle; with no grant, mem_we_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-012 SHALL require each requester to hold req and its payload stable until gnt is seen; a transfer completes on any cycle with req=1 and gnt=1.
REQ-013 SHALL, for a granted read (we=0), assert that port's rvalid for exactly one cycle, in the next cycle, with rdata = mem_rdata_i.
REQ-014 SHALL NOT assert rvalid for granted writes.
REQ-015 SHALL drive c_rdata_o and d_rdata_o from mem_rdata_i at all times; they are meaningful only while the matching rvalid is high.
REQ-016 SHALL support back-to-back grants every cycle, with read responses pipelined one cycle behind.
REQ-017 SHALL, with only one requester active, grant it immediately regardless of arbitration state.
REQ-018 SHALL, in fixed-priority mode, grant CPU on contention except when the starvation counter equals STARVE_LIMIT, in which case DMA is granted.
REQ-019 SHALL increment the starvation counter on each cycle d_req_i=1 and d_gnt_o=0, saturating at STARVE_LIMIT, and clear it on any DMA grant or when d_req_i=0.
REQ-020 SHALL pass addresses unmodified; word alignment and the 4 KiB range are the memory wrapper's concern.

Reset
REQ-021 SHALL, while rst_n=0, hold c_rvalid_o=0, d_rvalid_o=0, both gnt=0, mem_we_o=0, starvation counter=0, and round-robin pointer=CPU.
REQ-022 SHALL discard any read response pending when reset asserts; no rvalid appears after reset release without a new grant.

Configuration
REQ-023 SHALL provide macro DRAM_ARB_RR_EN: when defined, contention is resolved round-robin (the requester not granted last wins; pointer updates on every grant) and the starvation counter is not implemented; when undefined, fixed priority with starvation guard per REQ-018/019.

Structure
REQ-024 SHALL take `WIDTH and `ADDR_WIDTH from the shared defines header; requester index constants (CPU=0, DMA=1) SHALL live in the shared package.
REQ-025 SHALL be a single module with no sub-modules; the response-tag register (valid plus requester id) SHALL be local.

Verification
REQ-026 CPU read alone at 0x010 after writing 0xDEADBEEF there -> c_gnt_o same cycle, c_rvalid_o next cycle with c_rdata_o=0xDEADBEEF, d_rvalid_o stays 0.
REQ-027 Both request reads every cycle, fixed priority, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA on the 5th, counter cleared, pattern repeats.
REQ-028 Same stimulus with DRAM_ARB_RR_EN -> grants alternate CPU, DMA, CPU, DMA; each rvalid follows its grant by one cycle.
REQ-029 DMA write 0x12345678 to 0x020 contending with CPU read of 0x020 (RR, pointer=DMA) -> write first, CPU read next cycle returns 0x12345678, no d_rvalid_o.
REQ-030 rst_n pulled low the cycle after a CPU read grant -> c_rvalid_o never asserts; after release all outputs match REQ-021.
REQ-031 No requests for 10 cycles -> mem_we_o=0, no gnt, no rvalid throughout.
